// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: APB slave that loads, starts and collects the 16-lane accelerator.
// Define ACC_SEQ_CTRL_IRQ_EN to add the irq_o completion interrupt.
module acc_seq_ctrl #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      acc_start,
  input  logic                      acc_done,
  output logic [15:0][7:0]          acc_in_A,
  output logic [15:0][7:0]          acc_in_B,
  input  logic [15:0][15:0]         acc_out
`ifdef ACC_SEQ_CTRL_IRQ_EN
  ,
  output logic                      irq_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CAPT
  } state_t;

  localparam logic [15:0] TC_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           state_n;
  logic [3:0][31:0] opa;
  logic [3:0][31:0] opb;
  logic [7:0][31:0] res;
  logic [15:0]      cnt;
  logic             done;
  logic             tout;
  logic             irq_en;
  logic [9:0]       idx;
  logic [1:0]       opa_i;
  logic [1:0]       opb_i;
  logic [2:0]       res_i;
  logic             acc;
  logic             wr;
  logic             busy;
  logic             is_ctrl;
  logic             is_opa;
  logic             is_opb;
  logic             is_stat;
  logic             is_res;
  logic             bad_wr;
  logic             start_req;
  logic             clr_req;
  logic             tmo_hit;
  logic             unused;

  assign unused  = ^PADDR[1:0];
  assign idx     = PADDR[11:2];
  assign acc     = PSEL & PENABLE;
  assign wr      = acc & PWRITE;
  assign busy    = (state != S_IDLE);
  assign is_ctrl = (idx == 10'd0);
  assign is_opa  = (idx >= 10'd1) && (idx <= 10'd4);
  assign is_opb  = (idx >= 10'd5) && (idx <= 10'd8);
  assign is_stat = (idx == 10'd9);
  assign is_res  = (idx >= 10'd10) && (idx <= 10'd17);
  assign opa_i   = 2'(idx - 10'd1);
  assign opb_i   = 2'(idx - 10'd5);
  assign res_i   = 3'(idx - 10'd10);

  // A busy run locks the operands and the start bit only.
  assign bad_wr    = wr & busy &
                     (is_opa | is_opb | (is_ctrl & PWDATA[0]));
  assign start_req = wr & is_ctrl & PWDATA[0] & ~busy;
  assign clr_req   = wr & is_ctrl & PWDATA[1];
  assign tmo_hit   = (state == S_WAIT) & ~acc_done &
                     (cnt == TC_LAST);

  assign PREADY    = 1'b1;
  assign PSLVERR   = acc & ((idx > 10'd17) | bad_wr);
  assign acc_start = (state == S_START);
  assign acc_in_A  = opa;
  assign acc_in_B  = opb;

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start_req) state_n = S_START;
      S_START: state_n = S_WAIT;
      S_WAIT: begin
        if (acc_done)            state_n = S_CAPT;
        else if (cnt == TC_LAST) state_n = S_IDLE;
      end
      S_CAPT:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= S_IDLE;
      opa   <= '0;
      opb   <= '0;
      res   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      tout  <= 1'b0;
    end else begin
      state <= state_n;
      if (wr && is_opa && !busy) opa[opa_i] <= PWDATA;
      if (wr && is_opb && !busy) opb[opb_i] <= PWDATA;
      if (start_req) begin
        cnt  <= '0;
        done <= 1'b0;
        tout <= 1'b0;
      end else if (clr_req) begin
        done <= 1'b0;
        tout <= 1'b0;
      end
      if (state == S_WAIT && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      // Completion beats a same-cycle CLR_DONE.
      if (state == S_CAPT) begin
        res  <= acc_out;
        done <= 1'b1;
      end
      if (tmo_hit) begin
        done <= 1'b1;
        tout <= 1'b1;
      end
    end
  end

`ifdef ACC_SEQ_CTRL_IRQ_EN
  logic irq_q;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irq_en <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      if (wr && is_ctrl) irq_en <= PWDATA[2];
      irq_q <= done & irq_en;
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_en = 1'b0;
`endif

  always_comb begin
    PRDATA = '0;
    unique case (1'b1)
      is_ctrl: PRDATA = {29'b0, irq_en, 2'b0};
      is_opa:  PRDATA = opa[opa_i];
      is_opb:  PRDATA = opb[opb_i];
      is_stat: PRDATA = {cnt, 13'b0, tout, done, busy};
      is_res:  PRDATA = res[res_i];
      default: PRDATA = '0;
    endcase
  end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// tb_acc_seq_ctrl: directed and random APB traffic against a cycle-age model.
// Build with ACC_SEQ_CTRL_IRQ_EN defined to cover irq_o as well.
module tb_acc_seq_ctrl;

  localparam int T = 8;

  logic             HCLK = 1'b0;
  logic             HRESETn = 1'b0;
  logic [11:0]      PADDR = '0;
  logic [31:0]      PWDATA = '0;
  logic             PWRITE = 1'b0;
  logic             PSEL = 1'b0;
  logic             PENABLE = 1'b0;
  logic [31:0]      PRDATA;
  logic             PREADY;
  logic             PSLVERR;
  logic             acc_start;
  logic             acc_done;
  logic [15:0][7:0] acc_in_A;
  logic [15:0][7:0] acc_in_B;
  logic [15:0][15:0] acc_out;
`ifdef ACC_SEQ_CTRL_IRQ_EN
  logic             irq;
`endif

  logic dir_done = 1'b0;
  logic noise = 1'b0;
  logic rnd_en = 1'b0;
  int   nvec = 0;
  int   nerr = 0;
  int   starts = 0;

  always #5 HCLK = ~HCLK;

  assign acc_done = dir_done | noise;

  // Accelerator stand-in: lane-wise byte product.
  always_comb begin
    acc_out = '0;
    for (int l = 0; l < 16; l++)
      acc_out[l] = 16'(acc_in_A[l]) * 16'(acc_in_B[l]);
  end

  acc_seq_ctrl #(
    .APB_ADDR_WIDTH(12),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PWRITE    (PWRITE),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .acc_start (acc_start),
    .acc_done  (acc_done),
    .acc_in_A  (acc_in_A),
    .acc_in_B  (acc_in_B),
    .acc_out   (acc_out)
`ifdef ACC_SEQ_CTRL_IRQ_EN
    ,
    .irq_o     (irq)
`endif
  );

  // Model: a run is tracked by its age in cycles since the start write.
  bit          m_busy, m_capt, m_done, m_tout, m_irqen, m_irq;
  int          m_age, m_cnt;
  logic [31:0] m_opa [4];
  logic [31:0] m_opb [4];
  logic [15:0] m_res [16];

  function automatic logic [15:0] prod(input int l);
    logic [7:0] a;
    logic [7:0] b;
    a = m_opa[l/4][8*(l%4) +: 8];
    b = m_opb[l/4][8*(l%4) +: 8];
    return 16'(a) * 16'(b);
  endfunction

  function automatic logic [31:0] exp_rd(input int ix);
    if (ix == 0) return {29'b0, m_irqen, 2'b0};
    if (ix >= 1 && ix <= 4) return m_opa[ix-1];
    if (ix >= 5 && ix <= 8) return m_opb[ix-5];
    if (ix == 9)
      return {16'(m_cnt), 13'b0, m_tout, m_done, m_busy};
    if (ix >= 10 && ix <= 17)
      return {m_res[2*(ix-10)+1], m_res[2*(ix-10)]};
    return 32'h0;
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin : model
    bit busy0, done0, irqen0, wr;
    int ix;
    if (!HRESETn) begin
      m_busy = 0; m_capt = 0; m_done = 0; m_tout = 0;
      m_irqen = 0; m_irq = 0; m_age = 0; m_cnt = 0;
      for (int i = 0; i < 4; i++) begin
        m_opa[i] = '0;
        m_opb[i] = '0;
      end
      for (int i = 0; i < 16; i++) m_res[i] = '0;
    end else begin
      busy0  = m_busy;
      done0  = m_done;
      irqen0 = m_irqen;
      wr = PSEL && PENABLE && PWRITE;
      ix = int'(PADDR[11:2]);
      if (wr && ix == 0) begin
        if (PWDATA[0] && !busy0) begin
          m_busy = 1; m_capt = 0; m_age = 0;
          m_cnt = 0; m_done = 0; m_tout = 0;
        end else if (PWDATA[1]) begin
          m_done = 0; m_tout = 0;
        end
`ifdef ACC_SEQ_CTRL_IRQ_EN
        m_irqen = PWDATA[2];
`endif
      end
      if (wr && !busy0 && ix >= 1 && ix <= 4) m_opa[ix-1] = PWDATA;
      if (wr && !busy0 && ix >= 5 && ix <= 8) m_opb[ix-5] = PWDATA;
      if (busy0) begin
        if (m_capt) begin
          for (int l = 0; l < 16; l++) m_res[l] = prod(l);
          m_done = 1; m_busy = 0; m_capt = 0;
        end else if (m_age >= 1) begin
          m_cnt = (m_age > 65535) ? 65535 : m_age;
          if (acc_done) m_capt = 1;
          else if (m_age == T) begin
            m_done = 1; m_tout = 1; m_busy = 0;
          end
        end
        m_age++;
      end
      m_irq = done0 & irqen0;
    end
  end

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge HCLK) begin : cmp
    bit a, ee;
    int ix;
    logic [127:0] ea, eb;
    #2;
    if (HRESETn) begin
      a  = PSEL && PENABLE;
      ix = int'(PADDR[11:2]);
      ee = a && (ix > 17 || (PWRITE && m_busy &&
           ((ix >= 1 && ix <= 8) || (ix == 0 && PWDATA[0]))));
      for (int l = 0; l < 16; l++) begin
        ea[8*l +: 8] = m_opa[l/4][8*(l%4) +: 8];
        eb[8*l +: 8] = m_opb[l/4][8*(l%4) +: 8];
      end
      chk("pslverr", PSLVERR, ee);
      chk("acc_start", acc_start, m_busy && m_age == 0);
      chk("pready", PREADY, 1'b1);
      chk("acc_in", {acc_in_B, acc_in_A}, {eb, ea});
      if (a && !PWRITE) chk("prdata", PRDATA, exp_rd(ix));
`ifdef ACC_SEQ_CTRL_IRQ_EN
      chk("irq", irq, m_irq);
`endif
      if (acc_start) starts++;
    end
  end

  always @(negedge HCLK)
    noise = rnd_en && ($urandom_range(0, 4) == 0);

  task automatic apb_wr(input int ix, input logic [31:0] d,
                        output logic err);
    @(negedge HCLK);
    PADDR = 12'(ix * 4); PWDATA = d; PWRITE = 1'b1;
    PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge HCLK);
    PENABLE = 1'b1;
    #1 err = PSLVERR;
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input int ix, output logic [31:0] d,
                        output logic err);
    @(negedge HCLK);
    PADDR = 12'(ix * 4); PWRITE = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b0;
    @(negedge HCLK);
    PENABLE = 1'b1;
    #1 begin d = PRDATA; err = PSLVERR; end
    @(negedge HCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    logic [31:0] d;
    logic e;
    bit idle;
    idle = 0;
    for (int i = 0; i < 40 && !idle; i++) begin
      apb_rd(9, d, e);
      idle = !d[0];
    end
    if (!idle) begin
      nvec++;
      nerr++;
      $display("FAIL %s: BUSY still set after 40 polls", nm);
    end
  endtask

  initial begin : main
    logic [31:0] d;
    logic e;
    int s0, k, ix;

    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    #1 chk("rst_acc_start", acc_start, 1'b0);
    apb_rd(0, d, e);  chk("rst_ctrl", d, 32'h0);
    chk("rst_err", e, 1'b0);
    apb_rd(9, d, e);  chk("rst_status", d, 32'h0);
    apb_rd(10, d, e); chk("rst_res0", d, 32'h0);

    // Completed run: done on the 4th WAIT cycle.
    apb_wr(1, 32'h04030201, e);
    apb_wr(5, 32'h08070605, e);
    s0 = starts;
    apb_wr(0, 32'h1, e);
    repeat (4) @(negedge HCLK);
    dir_done = 1'b1;
    @(negedge HCLK);
    dir_done = 1'b0;
    apb_rd(10, d, e); chk("res_w10", d, 32'h000C0005);
    apb_rd(9, d, e);  chk("status_done", d, 32'h00040002);
    chk("one_start", starts - s0, 1);

    // Timeout run.
    apb_wr(0, 32'h1, e);
    wait_idle("tmo_wait");
    apb_rd(9, d, e);
    chk("tmo_bits", d[2:0], 3'b110);
    chk("tmo_cnt", d[31:16], 16'd8);
    apb_rd(10, d, e); chk("tmo_res_kept", d, 32'h000C0005);

    // Writes rejected while busy.
    apb_wr(2, 32'h11223344, e);
    s0 = starts;
    apb_wr(0, 32'h1, e);
    apb_wr(2, 32'hFFFFFFFF, e); chk("busy_opa_err", e, 1'b1);
    apb_wr(0, 32'h1, e);        chk("busy_start_err", e, 1'b1);
    wait_idle("busy_wait");
    apb_rd(2, d, e); chk("opa2_kept", d, 32'h11223344);
    chk("no_second_start", starts - s0, 1);

    apb_rd(20, d, e);
    chk("bad_idx_data", d, 32'h0);
    chk("bad_idx_err", e, 1'b1);

    // Reset in START kills the pulse at once.
    apb_wr(0, 32'h1, e);
    #1 chk("start_pulse", acc_start, 1'b1);
    HRESETn = 1'b0;
    #1 chk("rst_kills_start", acc_start, 1'b0);
    @(negedge HCLK) HRESETn = 1'b1;

    // Reset in WAIT.
    apb_wr(1, 32'hA5A5A5A5, e);
    apb_wr(0, 32'h1, e);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b0;
    #1 chk("rst_wait_start", acc_start, 1'b0);
    @(negedge HCLK) HRESETn = 1'b1;
    apb_rd(9, d, e); chk("rst_mid_status", d, 32'h0);
    apb_rd(1, d, e); chk("rst_mid_opa1", d, 32'h0);

`ifdef ACC_SEQ_CTRL_IRQ_EN
    apb_wr(0, 32'h5, e);
    @(negedge HCLK) dir_done = 1'b1;
    @(negedge HCLK) dir_done = 1'b0;
    wait_idle("irq_wait");
    chk("irq_hi", irq, 1'b1);
    apb_wr(0, 32'h6, e);
    chk("irq_hold", irq, 1'b1);
    @(negedge HCLK);
    #1 chk("irq_low", irq, 1'b0);
`endif

    rnd_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 9);
      if (k <= 2) begin
        d = $urandom;
        d[0] = ($urandom_range(0, 2) == 0);
        apb_wr(0, d, e);
      end else if (k <= 4) begin
        apb_wr($urandom_range(1, 8), $urandom, e);
      end else if (k <= 7) begin
        apb_rd($urandom_range(0, 23), d, e);
      end else if (k == 8) begin
        ix = $urandom_range(0, 23);
        apb_wr(ix, $urandom, e);
      end else begin
        repeat ($urandom_range(1, 6)) @(negedge HCLK);
      end
    end
    rnd_en = 1'b0;
    repeat (4) @(negedge HCLK);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
